// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU op-codes and the
// ID/EX control bundle carried alongside the decoded operands.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src_b;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
  } id_ex_ctrl_t;

  // rs2 is only a true source when it feeds ALU B, is stored, or is compared.
  function automatic logic rs2_used(input logic alu_src_b, input logic mem_write,
                                    input logic branch);
    return !alu_src_b || mem_write || branch;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Priority forwarding select for one source operand.
// EX/MEM beats MEM/WB; register x0 is never forwarded.
module fwd_mux #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_src_addr,
  input  logic [XLEN-1:0]   i_reg_data,
  input  logic              i_exmem_reg_write,
  input  logic [REG_AW-1:0] i_exmem_rd,
  input  logic [XLEN-1:0]   i_exmem_res,
  input  logic              i_memwb_reg_write,
  input  logic [REG_AW-1:0] i_memwb_rd,
  input  logic [XLEN-1:0]   i_memwb_data,
  output logic [XLEN-1:0]   o_data
);

  logic w_nonzero;
  assign w_nonzero = (i_src_addr != '0);

  // Pick the youngest in-flight producer of this register, else the file value.
  always_comb begin
    o_data = i_reg_data;
    if (w_nonzero && i_exmem_reg_write && (i_exmem_rd == i_src_addr))
      o_data = i_exmem_res;
    else if (w_nonzero && i_memwb_reg_write && (i_memwb_rd == i_src_addr))
      o_data = i_memwb_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the EX-stage ALU.
// Holds one decoded instruction, inserts a bubble on load-use hazards and
// forwards EX/MEM and MEM/WB results onto the registered operands.
// Macro ID_EX_FORWARD_EN: when defined, forwarding is built; when undefined
// the operands come straight from the register and any pending RAW stalls.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [2:0]        in_alu_op,
  input  logic              in_alu_src_b,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_branch,
  input  logic              flush,
  input  logic              out_ready,
  input  logic              exmem_reg_write,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [XLEN-1:0]   exmem_res,
  input  logic [XLEN-1:0]   memwb_data,
  output logic              out_valid,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [XLEN-1:0]   store_data,
  output logic [XLEN-1:0]   out_pc,
  output logic [2:0]        alu_op,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_branch
);

  import cpu_pkg::*;

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;
  id_ex_ctrl_t       r_ctrl;

  logic              w_rs2_used;
  logic              w_match_q;
  logic              w_load_use;
  logic              w_hazard;
  logic [XLEN-1:0]   w_op_a;
  logic [XLEN-1:0]   w_op_b;

  assign w_rs2_used = rs2_used(in_alu_src_b, in_mem_write, in_branch);
  assign w_match_q  = (in_rs1 == r_rd) || (w_rs2_used && (in_rs2 == r_rd));
  assign w_load_use = in_valid && r_valid && r_ctrl.mem_read && (r_rd != '0) && w_match_q;

`ifdef ID_EX_FORWARD_EN
  assign w_hazard = w_load_use;

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .i_src_addr       (r_rs1),
    .i_reg_data       (r_rs1_data),
    .i_exmem_reg_write(exmem_reg_write),
    .i_exmem_rd       (exmem_rd),
    .i_exmem_res      (exmem_res),
    .i_memwb_reg_write(memwb_reg_write),
    .i_memwb_rd       (memwb_rd),
    .i_memwb_data     (memwb_data),
    .o_data           (w_op_a)
  );

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .i_src_addr       (r_rs2),
    .i_reg_data       (r_rs2_data),
    .i_exmem_reg_write(exmem_reg_write),
    .i_exmem_rd       (exmem_rd),
    .i_exmem_res      (exmem_res),
    .i_memwb_reg_write(memwb_reg_write),
    .i_memwb_rd       (memwb_rd),
    .i_memwb_data     (memwb_data),
    .o_data           (w_op_b)
  );
`else
  logic w_raw_q;
  logic w_raw_ex;
  logic w_unused;

  // Without forwarding, any producer still in ID/EX or EX/MEM must retire first.
  assign w_raw_q  = in_valid && r_valid && r_ctrl.reg_write && (r_rd != '0) && w_match_q;
  assign w_raw_ex = in_valid && exmem_reg_write && (exmem_rd != '0) &&
                    ((in_rs1 == exmem_rd) || (w_rs2_used && (in_rs2 == exmem_rd)));
  assign w_hazard = w_load_use || w_raw_q || w_raw_ex;
  assign w_op_a   = r_rs1_data;
  assign w_op_b   = r_rs2_data;
  assign w_unused = ^{exmem_res, memwb_reg_write, memwb_rd, memwb_data, r_rs1, r_rs2};
`endif

  assign in_ready = out_ready && !w_hazard;

  // Stage register: reset, flush, back-pressure hold, bubble, then normal capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_ctrl     <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (!out_ready) begin
      r_valid <= r_valid;
    end else if (w_hazard) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else begin
      r_valid          <= in_valid;
      r_pc             <= in_pc;
      r_rs1_data       <= in_rs1_data;
      r_rs2_data       <= in_rs2_data;
      r_imm            <= in_imm;
      r_rs1            <= in_rs1;
      r_rs2            <= in_rs2;
      r_rd             <= in_rd;
      r_ctrl.alu_op    <= in_alu_op;
      r_ctrl.alu_src_b <= in_alu_src_b;
      r_ctrl.reg_write <= in_reg_write;
      r_ctrl.mem_read  <= in_mem_read;
      r_ctrl.mem_write <= in_mem_write;
      r_ctrl.branch    <= in_branch;
    end
  end

  assign out_valid     = r_valid;
  assign out_pc        = r_pc;
  assign out_rd        = r_rd;
  assign alu_op        = r_ctrl.alu_op;
  assign alu_a         = w_op_a;
  assign store_data    = w_op_b;
  assign alu_b         = r_ctrl.alu_src_b ? r_imm : w_op_b;
  assign out_reg_write = r_valid && r_ctrl.reg_write;
  assign out_mem_read  = r_valid && r_ctrl.mem_read;
  assign out_mem_write = r_valid && r_ctrl.mem_write;
  assign out_branch    = r_valid && r_ctrl.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: scoreboard of accepted instructions
// plus per-scenario directed checks.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [2:0]  in_alu_op;
  logic        in_alu_src_b, in_reg_write, in_mem_read, in_mem_write, in_branch;
  logic        flush, out_ready;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_res, memwb_data;
  logic        out_valid;
  logic [31:0] alu_a, alu_b, store_data, out_pc;
  logic [2:0]  alu_op;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_mem_read, out_mem_write, out_branch;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [2:0]  op;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   fails  = 0;
  bit   monEn  = 1'b0;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_alu_op(in_alu_op), .in_alu_src_b(in_alu_src_b), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_branch(in_branch),
    .flush(flush), .out_ready(out_ready),
    .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_res(exmem_res), .memwb_data(memwb_data),
    .out_valid(out_valid), .alu_a(alu_a), .alu_b(alu_b), .store_data(store_data),
    .out_pc(out_pc), .alu_op(alu_op), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_branch(out_branch)
  );

  always #5 clk = ~clk;

  // Reference result for the instruction currently on the inputs (no forward active).
  function automatic exp_t mkExp();
    exp_t e;
    e.a  = in_rs1_data;
    e.b  = in_alu_src_b ? in_imm : in_rs2_data;
    e.sd = in_rs2_data;
    e.pc = in_pc;
    e.rd = in_rd;
    e.op = in_alu_op;
    e.rw = in_reg_write;
    e.mr = in_mem_read;
    e.mw = in_mem_write;
    e.br = in_branch;
    return e;
  endfunction

  task automatic setInstr(input logic [31:0] pc, input logic [31:0] r1d, input logic [31:0] r2d,
                          input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [2:0] op, input logic srcb,
                          input logic rw, input logic mr, input logic mw, input logic br);
    in_pc = pc; in_rs1_data = r1d; in_rs2_data = r2d; in_imm = imm;
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_alu_op = op;
    in_alu_src_b = srcb; in_reg_write = rw; in_mem_read = mr; in_mem_write = mw; in_branch = br;
  endtask

  // Offer the current instruction until accepted, recording it in the scoreboard.
  task automatic issue();
    bit ok = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back(mkExp());
        ok = 1'b1;
      end
      @(posedge clk); #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL issue_accept: in_ready=%0b never high, required 1 within 20 cycles", in_ready);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every consumed output must match the oldest accepted instruction.
  always @(negedge clk) begin
    if (monEn && !rst && out_valid && out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        fails++;
        $display("[TB] FAIL sb_unexpected: out_valid=1 pc=%h, required no output", out_pc);
      end else begin
        exp_t e, o;
        e = sbq.pop_front();
        o = '{alu_a, alu_b, store_data, out_pc, out_rd, alu_op,
              out_reg_write, out_mem_read, out_mem_write, out_branch};
        if (o !== e) begin
          fails++;
          $display("[TB] FAIL sb_output: got %h, required %h", o, e);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0; exmem_rd = '0; memwb_rd = '0;
    exmem_res = '0; memwb_data = '0;
    setInstr(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, alu_a, alu_b, store_data, out_pc, alu_op, out_rd,
         out_reg_write, out_mem_read, out_mem_write, out_branch} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: valid=%0b a=%h b=%h sd=%h pc=%h, required all 0",
               out_valid, alu_a, alu_b, store_data, out_pc);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    monEn = 1'b1;
  endtask

  task automatic test_reset_mid();
    monEn = 1'b0;
    setInstr(32'h100, 32'h7, 32'h8, 32'h9, 5'd1, 5'd2, 5'd3, 3'b011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_reset_pre: out_valid=%0b, required 1", out_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_reg_write, out_mem_write, out_branch, alu_op, out_pc, alu_a} !== '0) begin
      fails++;
      $display("[TB] FAIL mid_reset_async: valid=%0b rw=%0b mw=%0b op=%0d pc=%h a=%h, required 0",
               out_valid, out_reg_write, out_mem_write, alu_op, out_pc, alu_a);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_reset_ready: in_ready=%0b, required 1", in_ready);
    end
    @(posedge clk); #1;
    monEn = 1'b1;
  endtask

  task automatic test_back_to_back();
    idle(2);
    setInstr(32'h10, 32'd10, 32'd5, 32'h99, 5'd1, 5'd2, 5'd3, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL b2b_ready1: in_ready=%0b, required 1", in_ready);
    end
    sbq.push_back(mkExp());
    @(posedge clk); #1;
    setInstr(32'h14, 32'h20, 32'h30, 32'h4, 5'd6, 5'd7, 5'd8, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL b2b_ready2: in_ready=%0b, required 1", in_ready);
    end
    sbq.push_back(mkExp());
    checks++;
    if ({out_valid, alu_a, alu_b} !== {1'b1, 32'd10, 32'd5}) begin
      fails++;
      $display("[TB] FAIL b2b_first: valid=%0b a=%0d b=%0d, required 1/10/5", out_valid, alu_a, alu_b);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, alu_b} !== {1'b1, 32'h4}) begin
      fails++;
      $display("[TB] FAIL b2b_second: valid=%0b b=%h, required 1/4", out_valid, alu_b);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    idle(2);
    setInstr(32'h20, 32'h40, 32'h0, 32'h8, 5'd1, 5'd0, 5'd5, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    issue();
    setInstr(32'h24, 32'h1, 32'h2, 32'h0, 5'd1, 5'd5, 5'd6, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL lu_stall: in_ready=%0b, required 0", in_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({out_valid, out_reg_write, in_ready} !== 3'b001) begin
      fails++;
      $display("[TB] FAIL lu_bubble: valid=%0b rw=%0b ready=%0b, required 0/0/1",
               out_valid, out_reg_write, in_ready);
    end
    if (in_ready) sbq.push_back(mkExp());
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL lu_capture: out_valid=%0b, required 1", out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_stall();
    idle(2);
    monEn = 1'b0;
    setInstr(32'h30, 32'h3, 32'h4, 32'h5, 5'd1, 5'd2, 5'd11, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({out_valid, out_pc} !== {1'b1, 32'h30}) begin
      fails++;
      $display("[TB] FAIL hold: valid=%0b pc=%h, required 1/00000030", out_valid, out_pc);
    end
    @(posedge clk); #1;
    flush = 1'b1;
    setInstr(32'h34, 32'hA, 32'hB, 32'hC, 5'd1, 5'd2, 5'd12, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flush: out_valid=%0b, required 0", out_valid);
    end
    @(posedge clk); #1;
    monEn = 1'b1;
    setInstr(32'h38, 32'h55, 32'h66, 32'h77, 5'd13, 5'd14, 5'd15, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    issue();
    idle(1);
  endtask

`ifdef ID_EX_FORWARD_EN
  task automatic test_forward();
    idle(2);
    monEn = 1'b0;
    setInstr(32'h50, 32'h44, 32'h55, 32'h0, 5'd4, 5'd2, 5'd10, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exmem_reg_write = 1'b1; exmem_rd = 5'd4; exmem_res = 32'h11;
    memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_data = 32'h22;
    #1;
    checks++;
    if ({alu_a, store_data} !== {32'h11, 32'h55}) begin
      fails++;
      $display("[TB] FAIL fwd_priority: a=%h sd=%h, required 11/55", alu_a, store_data);
    end
    exmem_reg_write = 1'b0;
    #1;
    checks++;
    if (alu_a !== 32'h22) begin
      fails++;
      $display("[TB] FAIL fwd_memwb: a=%h, required 22", alu_a);
    end
    memwb_rd = 5'd2;
    #1;
    checks++;
    if ({alu_a, alu_b, store_data} !== {32'h44, 32'h22, 32'h22}) begin
      fails++;
      $display("[TB] FAIL fwd_rs2: a=%h b=%h sd=%h, required 44/22/22", alu_a, alu_b, store_data);
    end
    memwb_reg_write = 1'b0;
    setInstr(32'h54, 32'h66, 32'h1, 32'h0, 5'd0, 5'd2, 5'd10, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_res = 32'h33;
    #1;
    checks++;
    if (alu_a !== 32'h66) begin
      fails++;
      $display("[TB] FAIL fwd_x0: a=%h, required 66", alu_a);
    end
    exmem_reg_write = 1'b0; exmem_res = '0;
    @(posedge clk); #1;
    monEn = 1'b1;
  endtask
`else
  task automatic test_no_forward();
    idle(2);
    exmem_reg_write = 1'b1; exmem_rd = 5'd7; exmem_res = 32'h99;
    setInstr(32'h40, 32'h70, 32'h3, 32'h1, 5'd7, 5'd0, 5'd9, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        fails++;
        $display("[TB] FAIL raw_stall%0d: in_ready=%0b, required 0", i, in_ready);
      end
      @(posedge clk); #1;
    end
    exmem_reg_write = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL raw_release: in_ready=%0b, required 1", in_ready);
    end
    if (in_ready) sbq.push_back(mkExp());
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, alu_a} !== {1'b1, 32'h70}) begin
      fails++;
      $display("[TB] FAIL raw_operand: valid=%0b a=%h, required 1/00000070", out_valid, alu_a);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_flush_stall();
`ifdef ID_EX_FORWARD_EN
    test_forward();
`else
    test_no_forward();
`endif
    test_reset_mid();
    idle(2);
    checks++;
    if (sbq.size() != 0) begin
      fails++;
      $display("[TB] FAIL sb_drain: %0d entries left, required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
